// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adder_seq_ctrl (with helper module adder)
//  Purpose  : Multi-precision add/subtract sequencer. Two W = 8*NBYTES bit
//             operands are latched on start and pushed through one shared
//             8-bit carry-lookahead adder, one byte per clock, LSB first.
//             The carry is chained through a register. Carry-out and signed
//             overflow are reported with a start/busy/done handshake.
//  Optional : define ADDSEQ_CARRY_IN_EN to add a cin port (carry-in for add,
//             borrow-in for subtract). When it is undefined, cin is 0.
//  Ports    : clk, rst_n (sync, active-low), start, op_sub, a_in[W], b_in[W],
//             [cin], busy, done (1-cycle pulse), result[W], cout, overflow
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 8-bit carry-lookahead adder. Every carry is a flattened generate/propagate
// product back to Cin, so no carry ripples through earlier carries.
// ----------------------------------------------------------------------------
module adder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       Cout
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       prop;

    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c    = '0;
        prop = 1'b0;
        c[0] = Cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i];
            prop   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prop & g[j]);
                prop   = prop & p[j];
            end
            c[i+1] = c[i+1] | (prop & Cin);
        end
        Sum  = p ^ c[7:0];
        Cout = c[8];
    end
endmodule

module adder_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                op_sub,
    input  logic [8*NBYTES-1:0] a_in,
    input  logic [8*NBYTES-1:0] b_in,
`ifdef ADDSEQ_CARRY_IN_EN
    input  logic                cin,
`endif
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                cout,
    output logic                overflow
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    // Sized constant, so the compare never overflows when NBYTES = 2^k.
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;          // holds B already inverted for subtract
    logic [W-1:0]    result_q, result_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic            carry_init;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      add_sum;
    logic            add_cout;

    // Borrow-in convention: for subtract, carry = ~borrow.
`ifdef ADDSEQ_CARRY_IN_EN
    assign carry_init = op_sub ^ cin;
`else
    assign carry_init = op_sub;
`endif

    // Byte select. This uses constant slices, so an index past NBYTES-1
    // cannot read out of range.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_byte = a_q[i*8 +: 8];
                b_byte = b_q[i*8 +: 8];
            end
        end
    end

    adder u_adder (
        .A    (a_byte),
        .B    (b_byte),
        .Cin  (carry_q),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = op_sub ? ~b_in : b_in;
                    carry_d = carry_init;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        result_d[i*8 +: 8] = add_sum;
                    end
                end
                carry_d = add_cout;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    // Same-sign operands that produce a different-sign sum.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_seq_ctrl
//  Purpose  : Scoreboard bench for adder_seq_ctrl (NBYTES = 4). The stimulus
//             pushes hand-computed expectations. A monitor pops one
//             expectation on every done pulse and compares it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_seq_ctrl;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, overflow;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        int           dcyc;
    } exp_t;
    exp_t sb[$];

    adder_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sub   (op_sub),
        .a_in     (a_in),
        .b_in     (b_in),
`ifdef ADDSEQ_CARRY_IN_EN
        .cin      (cin),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each done pulse consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("cout", {31'd0, cout}, {31'd0, e.c});
                chk("overflow", {31'd0, overflow}, {31'd0, e.o});
                chk("done_latency", cyc, e.dcyc);
            end
        end
    end

    // The caller is already at a negedge. Start is sampled by the next
    // posedge (E0), and done appears after E0+NBYTES.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic ci, input logic [W-1:0] er, input logic ec, input logic eo);
        exp_t e;
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        op_sub = sub;
        cin    = ci;
        e.res  = er;
        e.c    = ec;
        e.o    = eo;
        e.dcyc = cyc + 1 + NBYTES;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_timeout", W'(sb.size()), '0);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Busy is high for 4 cycles, then done pulses for exactly one cycle.
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        for (int k = 0; k < NBYTES; k++) begin
            #1 chk("busy_run", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        #1 chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("done_high", {31'd0, done}, 32'd1);
        @(negedge clk);
        #1 chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("result_held", result, 32'h0000_0100);
        drain();

        // Carry out and signed overflow cases
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0); drain();
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1); drain();
        issue(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0); drain();
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1); drain();

        // A start while busy is ignored. A start during done is accepted
        // with no bubble.
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; a_in = 32'hAAAA_AAAA; b_in = 32'h5555_5555; op_sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10 && done !== 1'b1; k++) begin
            @(negedge clk);
            #1;
        end
        chk("b2b_done_seen", {31'd0, done}, 32'd1);
        issue(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'hFFFF_FFF0, 1'b0, 1'b0);
        drain();

        // Reset in the middle of an operation aborts it.
        start = 1'b1; a_in = 32'h0101_0101; b_in = 32'h0101_0101; op_sub = 1'b0;
        @(negedge clk);        // after E0
        start = 1'b0;
        @(negedge clk);        // after E1
        rst_n = 1'b0;          // sampled at E2
        @(negedge clk);
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        chk("abort_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);   // the monitor flags any stray done
        issue(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 32'h0202_0202, 1'b0, 1'b0); drain();

`ifdef ADDSEQ_CARRY_IN_EN
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0); drain();
        issue(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0); drain();
`endif

        repeat (10) @(negedge clk);
        chk("sb_empty", W'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
